lsu_dmem: RTL and testbench
===========================

Name: lsu_dmem

Overview:
- MEM-stage load/store unit between the pipeline and a data memory with a request/grant/response interface.
- Formats store data and byte enables from the word/half/byte store type.
- Issues the bus transaction and stalls the pipeline until it completes.
- Aligns and sign/zero-extends load data, producing the ReadData value that the MEM/WB register carries to the writeback result select.

Parameters:
- WIDTH, 32, data and address width; byte-lane logic is fixed at 4 lanes, so only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- MemReqM  input  1  instruction in MEM is a load or store
- MemWriteM  input  1  1 = store, 0 = load
- Funct3M  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUResultM  input  WIDTH  byte address
- WriteDataM  input  WIDTH  store source register value
- StallM  output  1  freeze PC and IF/ID/EX/MEM registers
- MisalignM  output  1  one-cycle misaligned-access flag
- ReadDataM  output  WIDTH  extended load result
- dmem_req  output  1  bus request
- dmem_we  output  1  bus write
- dmem_addr  output  WIDTH  word address; bits [1:0] always 00
- dmem_wdata  output  WIDTH  lane-replicated store data
- dmem_be  output  4  byte enables
- dmem_gnt  input  1  request accepted this cycle
- dmem_rvalid  input  1  read data valid
- dmem_rdata  input  WIDTH  read data word

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE
  - dmem_req 0, dmem_we 0, dmem_addr 0, dmem_wdata 0, dmem_be 0
  - ReadDataM 0, StallM 0, MisalignM 0
  - Reset mid-transaction abandons the transaction; any later rvalid is ignored.
- Alignment check:
  - H/HU/SH need addr[0]=0.
  - W/SW need addr[1:0]=00.
  - Funct3 011/110/111 is treated as W.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - MemReqM and aligned: register address, we, be, wdata, funct3 and addr[1:0]; go to REQ.
  - StallM is combinationally high in this cycle.
  - MemReqM and misaligned: MisalignM=1 combinationally for that cycle; no bus request, no stall, stay in IDLE, ReadDataM unchanged.
- REQ:
  - dmem_req=1 from registers, held stable until dmem_gnt; StallM=1.
  - On gnt: store goes to DONE.
  - On gnt, load with dmem_rvalid in the same cycle: capture data, go to DONE.
  - On gnt, load otherwise: go to WAIT.
- WAIT:
  - dmem_req=0, StallM=1.
  - On dmem_rvalid: capture extended data into ReadDataM, go to DONE.
  - No timeout.
- DONE:
  - StallM=0, dmem_req=0, so the pipeline advances one cycle.
  - Unconditionally go to IDLE.
  - A back-to-back memory op is picked up in IDLE the following cycle.
- Minimum latency: 3 cycles per access (IDLE, REQ with gnt, DONE) for a store, or for a load with gnt+rvalid in the same cycle.
- Store formatting:
  - SB: be = 0001 << addr[1:0]; wdata = byte[7:0] replicated ×4.
  - SH: be = addr[1] ? 1100 : 0011; wdata = half[15:0] replicated ×2.
  - SW: be = 1111; wdata = WriteDataM.
- Load formatting: lane select by registered addr[1:0].
  - LB/LH: sign-extend to WIDTH.
  - LBU/LHU: zero-extend to WIDTH.
  - LW: word as-is.
  - For loads dmem_be = 1111.
- ReadDataM holds its value until the next load completes; stores never change it.
- dmem_rvalid in IDLE, REQ-before-gnt, or DONE is ignored.
- dmem_we=0 and dmem_be=0 whenever dmem_req=0.

Test Plan:
- Reset with dmem_req held active mid-REQ -> all outputs 0 asynchronously; state IDLE; a later rvalid does not change ReadDataM.
- SB: addr 0x1003, WriteDataM 0x000000A5, gnt on first REQ cycle -> dmem_addr 0x1000, be 1000, wdata 0xA5A5A5A5; StallM high 2 cycles then low in DONE.
- LB then LBU: addr 0x2002, rdata 0x0080_0000, rvalid 2 cycles after gnt -> ReadDataM 0xFFFFFF80 for LB, 0x00000080 for LBU; StallM high through WAIT.
- LH: addr 0x2002, rdata 0x8001_1234, gnt+rvalid in the same cycle -> ReadDataM 0xFFFF8001; WAIT skipped.
- LW: addr 0x3002 -> MisalignM=1 for one cycle, dmem_req never asserts, StallM stays 0, ReadDataM unchanged.
- gnt withheld 4 cycles during SW: addr 0x4000, data 0xDEADBEEF -> dmem_req/addr/wdata/be=1111 stable all 4 cycles; StallM high; completes on gnt.

Source files
------------

// File: rtl/lsu_dmem.sv
// MEM-stage load/store unit: formats stores, runs a req/gnt/rvalid bus
// transaction while stalling the pipeline, and aligns/extends load data.
module lsu_dmem #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             MemReqM,
   input  logic             MemWriteM,
   input  logic [2:0]       Funct3M,
   input  logic [WIDTH-1:0] ALUResultM,
   input  logic [WIDTH-1:0] WriteDataM,
   output logic             StallM,
   output logic             MisalignM,
   output logic [WIDTH-1:0] ReadDataM,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [WIDTH-1:0] dmem_addr,
   output logic [WIDTH-1:0] dmem_wdata,
   output logic [3:0]       dmem_be,
   input  logic             dmem_gnt,
   input  logic             dmem_rvalid,
   input  logic [WIDTH-1:0] dmem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] addr_q, wdata_q;
   logic [3:0]       be_q;
   logic             we_q;
   logic [2:0]       f3_q;
   logic [1:0]       lo_q;

   logic             is_b, is_h, mis;
   logic [3:0]       be_fmt;
   logic [WIDTH-1:0] wdata_fmt;
   logic             load, capture, req, stall, misal;

   // Reserved funct3 encodings fall through to word size.
   assign is_b = (Funct3M[1:0] == 2'b00);
   assign is_h = (Funct3M[1:0] == 2'b01);
   assign mis  = is_h ? ALUResultM[0] :
                 is_b ? 1'b0 : (ALUResultM[1:0] != 2'b00);

   always_comb begin
      be_fmt    = 4'b1111;
      wdata_fmt = WriteDataM;
      if (is_b) begin
         wdata_fmt = {4{WriteDataM[7:0]}};
         if (MemWriteM) be_fmt = 4'b0001 << ALUResultM[1:0];
      end else if (is_h) begin
         wdata_fmt = {2{WriteDataM[15:0]}};
         if (MemWriteM) be_fmt = ALUResultM[1] ? 4'b1100 : 4'b0011;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      capture   = 1'b0;
      req       = 1'b0;
      stall     = 1'b0;
      misal     = 1'b0;
      unique case (state)
         IDLE: begin
            if (MemReqM) begin
               if (mis) begin
                  misal = 1'b1;
               end else begin
                  load      = 1'b1;
                  stall     = 1'b1;
                  state_nxt = REQ;
               end
            end
         end
         REQ: begin
            req   = 1'b1;
            stall = 1'b1;
            if (dmem_gnt) begin
               if (we_q) begin
                  state_nxt = DONE;
               end else if (dmem_rvalid) begin
                  capture   = 1'b1;
                  state_nxt = DONE;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (dmem_rvalid) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Load lane select and extension from the registered access info.
   logic [WIDTH-1:0] rsh, rext;
   logic             uns;
   assign rsh = dmem_rdata >> {lo_q, 3'b000};
   assign uns = f3_q[2];

   always_comb begin
      unique case (f3_q[1:0])
         2'b00:   rext = {{(WIDTH-8){rsh[7] & ~uns}}, rsh[7:0]};
         2'b01:   rext = {{(WIDTH-16){rsh[15] & ~uns}}, rsh[15:0]};
         default: rext = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         we_q      <= 1'b0;
         f3_q      <= '0;
         lo_q      <= '0;
         ReadDataM <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            addr_q  <= {ALUResultM[WIDTH-1:2], 2'b00};
            wdata_q <= wdata_fmt;
            be_q    <= be_fmt;
            we_q    <= MemWriteM;
            f3_q    <= Funct3M;
            lo_q    <= ALUResultM[1:0];
         end
         if (capture) ReadDataM <= rext;
      end
   end

   assign StallM     = rst_n & stall;
   assign MisalignM  = rst_n & misal;
   assign dmem_req   = req;
   assign dmem_we    = req & we_q;
   assign dmem_be    = req ? be_q : 4'b0000;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem: stores, loads with varied rvalid timing,
// misalignment, grant back-pressure and asynchronous reset mid-request.
module tb_lsu_dmem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReqM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallM, MisalignM;
  logic [31:0] ReadDataM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_dmem #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .StallM(StallM), .MisalignM(MisalignM),
    .ReadDataM(ReadDataM),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic we, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] d);
    MemReqM    = 1'b1;
    MemWriteM  = we;
    Funct3M    = f3;
    ALUResultM = a;
    WriteDataM = d;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    MemReqM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
    ALUResultM = '0; WriteDataM = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    #12;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_rd", ReadDataM, 32'h0);
    chk("rst_stall", StallM, 1'b0);
    rst_n = 1'b1;
    tick();

    op(1'b1, 3'b000, 32'h1003, 32'h000000A5);
    chk("sb_idle_stall", StallM, 1'b1);
    chk("sb_idle_req", dmem_req, 1'b0);
    tick();
    dmem_gnt = 1'b1; #1;
    chk("sb_req", dmem_req, 1'b1);
    chk("sb_we", dmem_we, 1'b1);
    chk("sb_addr", dmem_addr, 32'h1000);
    chk("sb_be", dmem_be, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("sb_req_stall", StallM, 1'b1);
    tick();
    dmem_gnt = 1'b0; MemReqM = 1'b0; #1;
    chk("sb_done_stall", StallM, 1'b0);
    chk("sb_done_req", dmem_req, 1'b0);
    chk("sb_done_be", dmem_be, 4'b0000);
    tick();

    op(1'b1, 3'b001, 32'h0002, 32'h1234ABCD);
    tick();
    dmem_gnt = 1'b1; #1;
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    tick();
    dmem_gnt = 1'b0; MemReqM = 1'b0;
    tick();

    for (int k = 0; k < 2; k++) begin
      op(1'b0, (k == 0) ? 3'b000 : 3'b100, 32'h2002, 32'h0);
      tick();
      dmem_gnt = 1'b1; #1;
      chk("lb_req", dmem_req, 1'b1);
      chk("lb_we", dmem_we, 1'b0);
      chk("lb_be", dmem_be, 4'b1111);
      chk("lb_addr", dmem_addr, 32'h2000);
      tick();
      dmem_gnt = 1'b0; #1;
      chk("lb_wait_req", dmem_req, 1'b0);
      chk("lb_wait_stall", StallM, 1'b1);
      tick();
      dmem_rvalid = 1'b1; dmem_rdata = 32'h0080_0000; #1;
      chk("lb_wait2_stall", StallM, 1'b1);
      tick();
      dmem_rvalid = 1'b0; MemReqM = 1'b0; #1;
      chk("lb_done_stall", StallM, 1'b0);
      chk("lb_rdata", ReadDataM,
          (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
      tick();
    end

    op(1'b0, 3'b001, 32'h2002, 32'h0);
    tick();
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
    dmem_rdata = 32'h8001_1234;
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; MemReqM = 1'b0; #1;
    chk("lh_done_stall", StallM, 1'b0);
    chk("lh_rdata", ReadDataM, 32'hFFFF8001);
    tick();

    op(1'b0, 3'b010, 32'h3002, 32'h0);
    chk("mis_flag", MisalignM, 1'b1);
    chk("mis_stall", StallM, 1'b0);
    chk("mis_req", dmem_req, 1'b0);
    tick();
    MemReqM = 1'b0; #1;
    chk("mis_flag_off", MisalignM, 1'b0);
    chk("mis_req2", dmem_req, 1'b0);
    chk("mis_rd_hold", ReadDataM, 32'hFFFF8001);

    tick();
    op(1'b1, 3'b010, 32'h4000, 32'hDEADBEEF);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("sw_hold_req", dmem_req, 1'b1);
      chk("sw_hold_addr", dmem_addr, 32'h4000);
      chk("sw_hold_wdata", dmem_wdata, 32'hDEADBEEF);
      chk("sw_hold_be", dmem_be, 4'b1111);
      chk("sw_hold_stall", StallM, 1'b1);
      tick();
    end
    dmem_gnt = 1'b1; #1;
    chk("sw_gnt_req", dmem_req, 1'b1);
    tick();
    dmem_gnt = 1'b0; MemReqM = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555; #1;
    chk("sw_done_stall", StallM, 1'b0);
    tick();
    dmem_rvalid = 1'b0; #1;
    chk("sw_rd_hold", ReadDataM, 32'hFFFF8001);

    op(1'b0, 3'b010, 32'h5004, 32'h0);
    tick();
    chk("rst2_pre_req", dmem_req, 1'b1);
    #2;
    rst_n = 1'b0; #1;
    chk("rst2_req", dmem_req, 1'b0);
    chk("rst2_addr", dmem_addr, 32'h0);
    chk("rst2_be", dmem_be, 4'b0000);
    chk("rst2_stall", StallM, 1'b0);
    chk("rst2_rd", ReadDataM, 32'h0);
    MemReqM = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_rvalid = 1'b0;
    tick();
    chk("rst2_rd_after", ReadDataM, 32'h0);
    chk("rst2_req_after", dmem_req, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
